// File: rtl/sprite_pkg.sv
// Shared sprite geometry, screen limits, ball velocity type and ball FSM states.
package sprite_pkg;

    localparam int SCREEN_H_RES  = 640;
    localparam int SCREEN_V_RES  = 480;
    localparam int SCREEN_BORDER = 10;
    localparam int BALL_SIDE     = 10;
    localparam int X_POS_W       = 10;
    localparam int Y_POS_W       = 9;
    localparam int SPEED_W       = 4;

    // Axis-aligned rectangle: top-left corner plus exclusive right/bottom edges.
    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    // Per-axis velocity: dir = 1 means increasing coordinate (right / down).
    typedef struct packed {
        logic                 dir;
        logic [SPEED_W-2:0]   mag;
    } vel_t;

    typedef enum logic [2:0] {
        ST_WAIT_SERVE = 3'd0,
        ST_IDLE       = 3'd1,
        ST_MOVE       = 3'd2,
        ST_CHECK      = 3'd3,
        ST_SCORE      = 3'd4
    } ball_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic [X_POS_W-1:0] BALL_X = X_POS_W'(BALL_SIDE);
    localparam logic [Y_POS_W-1:0] BALL_Y = Y_POS_W'(BALL_SIDE);

    localparam logic [Y_POS_W-1:0] TOP_LIMIT    = Y_POS_W'(SCREEN_BORDER);
    localparam logic [Y_POS_W-1:0] BOTTOM_LIMIT = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER);
    localparam logic [X_POS_W-1:0] LEFT_GOAL    = X_POS_W'(SCREEN_BORDER);
    localparam logic [X_POS_W-1:0] RIGHT_GOAL   = X_POS_W'(SCREEN_H_RES - SCREEN_BORDER);

    // Largest top-left coordinate that keeps the ball fully on screen.
    localparam int X_MAX = SCREEN_H_RES - BALL_SIDE;
    localparam int Y_MAX = SCREEN_V_RES - BALL_SIDE;

    localparam logic [SPEED_W-2:0] INIT_SPEED_B     = (SPEED_W-1)'(4);
    localparam logic [SPEED_W-2:0] DEFLECT_SPEED_X  = (SPEED_W-1)'(4);
    localparam logic [SPEED_W-2:0] DEFLECT_SPEED_Y  = (SPEED_W-1)'(1);
    localparam logic [SPEED_W-2:0] SIDE_HIT_SPEED_Y = (SPEED_W-1)'(5);

    // Serve position: ball centred on screen.
    localparam sprite_t INIT_ST_B = '{
        x_pos:  X_POS_W'((SCREEN_H_RES - BALL_SIDE) / 2),
        y_pos:  Y_POS_W'((SCREEN_V_RES - BALL_SIDE) / 2),
        right:  X_POS_W'((SCREEN_H_RES - BALL_SIDE) / 2 + BALL_SIDE),
        bottom: Y_POS_W'((SCREEN_V_RES - BALL_SIDE) / 2 + BALL_SIDE)
    };

endpackage

// File: rtl/sprite_overlap.sv
// Combinational axis-aligned bounding-box overlap test between two sprites.
module sprite_overlap
    import sprite_pkg::*;
(
    input  sprite_t a_i,
    input  sprite_t b_i,
    output logic    hit_o
);

    // Edges are exclusive, so rectangles that only touch do not overlap.
    assign hit_o = (a_i.x_pos < b_i.right)  && (b_i.x_pos < a_i.right) &&
                   (a_i.y_pos < b_i.bottom) && (b_i.y_pos < a_i.bottom);

endmodule

// File: rtl/ball_ctrl.sv
// Per-frame ball motion, wall/paddle collision, miss detection and re-serve.
module ball_ctrl
    import sprite_pkg::*;
#(
    parameter logic START_DIR_X = 1'b1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    frame_tick_i,
    input  logic    serve_i,
    input  sprite_t player_i,
    input  sprite_t enemy_i,
    output sprite_t ball_o,
    output logic    score_p_o,
    output logic    score_e_o,
    output logic    busy_o
);

    // Two spare bits: one for carry past the screen edge, one for sign below zero.
    localparam int XS_W = X_POS_W + 2;
    localparam int YS_W = Y_POS_W + 2;
    localparam logic signed [XS_W-1:0] X_MAX_S = XS_W'(X_MAX);
    localparam logic signed [YS_W-1:0] Y_MAX_S = YS_W'(Y_MAX);

    ball_state_t state_q, state_d;
    logic        move_ph_q, move_ph_d;
    sprite_t     ball_q, ball_d;
    sprite_t     work_q, work_d;
    vel_t        vx_q, vx_d;
    vel_t        vy_q, vy_d;
    logic signed [XS_W-1:0] sx_q, sx_d;
    logic signed [YS_W-1:0] sy_q, sy_d;
    logic        score_p_q, score_p_d;
    logic        score_e_q, score_e_d;

    logic        hit_p, hit_e;
    logic        miss_p, miss_e;
    sprite_t     chk_s;
    vel_t        chk_vx, chk_vy;

    function automatic logic [X_POS_W-1:0] sat_x(input logic signed [XS_W-1:0] v);
        if (v[XS_W-1])    return '0;
        if (v > X_MAX_S)  return X_POS_W'(X_MAX);
        return v[X_POS_W-1:0];
    endfunction

    function automatic logic [Y_POS_W-1:0] sat_y(input logic signed [YS_W-1:0] v);
        if (v[YS_W-1])    return '0;
        if (v > Y_MAX_S)  return Y_POS_W'(Y_MAX);
        return v[Y_POS_W-1:0];
    endfunction

    // Paddle deflection: compare doubled centres to avoid halving odd heights.
    function automatic vel_t deflect(input logic [Y_POS_W-1:0] ball_y,
                                     input logic [Y_POS_W-1:0] pad_top,
                                     input logic [Y_POS_W-1:0] pad_bot,
                                     input vel_t               vy);
        int   off2;
        vel_t v;
        off2 = (2 * int'(ball_y) + BALL_SIDE) - (int'(pad_top) + int'(pad_bot));
        v    = vy;
        if (off2 > -2 * BALL_SIDE && off2 < 2 * BALL_SIDE) begin
            v.mag = DEFLECT_SPEED_Y;
        end else begin
            v.mag = SIDE_HIT_SPEED_Y;
            v.dir = (off2 > 0) ? DIR_DOWN : DIR_UP;
        end
        return v;
    endfunction

    sprite_overlap u_ovl_player (
        .a_i   (work_q),
        .b_i   (player_i),
        .hit_o (hit_p)
    );

    sprite_overlap u_ovl_enemy (
        .a_i   (work_q),
        .b_i   (enemy_i),
        .hit_o (hit_e)
    );

    // Collision resolution on the moved position; axes resolved independently.
    always_comb begin
        chk_s  = work_q;
        chk_vx = vx_q;
        chk_vy = vy_q;
        miss_p = 1'b0;
        miss_e = 1'b0;

        if (work_q.y_pos <= TOP_LIMIT && vy_q.dir == DIR_UP) begin
            chk_s.y_pos = TOP_LIMIT;
            chk_vy.dir  = DIR_DOWN;
        end else if (work_q.bottom >= BOTTOM_LIMIT && vy_q.dir == DIR_DOWN) begin
            chk_s.y_pos = BOTTOM_LIMIT - BALL_Y;
            chk_vy.dir  = DIR_UP;
        end

        // Paddle contact outranks a goal on the same frame.
        if (hit_p && vx_q.dir == DIR_RIGHT) begin
            chk_s.x_pos = player_i.x_pos - BALL_X;
            chk_vx      = '{dir: DIR_LEFT, mag: DEFLECT_SPEED_X};
            chk_vy      = deflect(work_q.y_pos, player_i.y_pos, player_i.bottom, chk_vy);
        end else if (hit_e && vx_q.dir == DIR_LEFT) begin
            chk_s.x_pos = enemy_i.right;
            chk_vx      = '{dir: DIR_RIGHT, mag: DEFLECT_SPEED_X};
            chk_vy      = deflect(work_q.y_pos, enemy_i.y_pos, enemy_i.bottom, chk_vy);
        end else if (work_q.x_pos <= LEFT_GOAL && vx_q.dir == DIR_LEFT) begin
            miss_p = 1'b1;
        end else if (work_q.right >= RIGHT_GOAL && vx_q.dir == DIR_RIGHT) begin
            miss_e = 1'b1;
        end

        chk_s.right  = chk_s.x_pos + BALL_X;
        chk_s.bottom = chk_s.y_pos + BALL_Y;
    end

    // Frame FSM; MOVE takes two cycles (raw sum, then clamp) so ball_o lands on the third edge.
    always_comb begin
        state_d   = state_q;
        move_ph_d = move_ph_q;
        ball_d    = ball_q;
        work_d    = work_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        score_p_d = 1'b0;
        score_e_d = 1'b0;

        case (state_q)
            ST_WAIT_SERVE: begin
                if (serve_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (frame_tick_i) begin
                    state_d   = ST_MOVE;
                    move_ph_d = 1'b0;
                end
            end
            ST_MOVE: begin
                if (!move_ph_q) begin
                    sx_d = vx_q.dir ? XS_W'(ball_q.x_pos) + XS_W'(vx_q.mag)
                                    : XS_W'(ball_q.x_pos) - XS_W'(vx_q.mag);
                    sy_d = vy_q.dir ? YS_W'(ball_q.y_pos) + YS_W'(vy_q.mag)
                                    : YS_W'(ball_q.y_pos) - YS_W'(vy_q.mag);
                    move_ph_d = 1'b1;
                end else begin
                    work_d.x_pos  = sat_x(sx_q);
                    work_d.y_pos  = sat_y(sy_q);
                    work_d.right  = sat_x(sx_q) + BALL_X;
                    work_d.bottom = sat_y(sy_q) + BALL_Y;
                    move_ph_d     = 1'b0;
                    state_d       = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (miss_p || miss_e) begin
                    // Re-serve toward whichever side conceded.
                    score_p_d = miss_p;
                    score_e_d = miss_e;
                    ball_d    = INIT_ST_B;
                    vx_d      = '{dir: (miss_p ? DIR_LEFT : DIR_RIGHT), mag: INIT_SPEED_B};
                    vy_d      = '{dir: DIR_DOWN, mag: DEFLECT_SPEED_Y};
                    state_d   = ST_SCORE;
                end else begin
                    ball_d  = chk_s;
                    vx_d    = chk_vx;
                    vy_d    = chk_vy;
                    state_d = ST_IDLE;
                end
            end
            ST_SCORE: begin
                state_d = ST_WAIT_SERVE;
            end
            default: begin
                state_d = ST_WAIT_SERVE;
            end
        endcase
    end

    // Architectural state: FSM, committed ball, velocities and score pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_WAIT_SERVE;
            move_ph_q <= 1'b0;
            ball_q    <= INIT_ST_B;
            vx_q      <= '{dir: START_DIR_X, mag: INIT_SPEED_B};
            vy_q      <= '{dir: DIR_DOWN, mag: DEFLECT_SPEED_Y};
            score_p_q <= 1'b0;
            score_e_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            move_ph_q <= move_ph_d;
            ball_q    <= ball_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            score_p_q <= score_p_d;
            score_e_q <= score_e_d;
        end
    end

    // Scratch position registers; only meaningful inside MOVE/CHECK.
    always_ff @(posedge clk_i) begin
        work_q <= work_d;
        sx_q   <= sx_d;
        sy_q   <= sy_d;
    end

    assign ball_o    = ball_q;
    assign score_p_o = score_p_q;
    assign score_e_o = score_e_q;
    assign busy_o    = (state_q == ST_MOVE) || (state_q == ST_CHECK) || (state_q == ST_SCORE);

endmodule
